// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants and helpers for the SHA-256 block engine.
//   - BLK_OP field accessor macros (bit positions within input_blk_op)
//   - round constants K[0:63], initial hash value IV
//   - sigma/rotate helpers and input byte swap
`ifndef SHA256_PKG_BLK_OP_MACROS
`define SHA256_PKG_BLK_OP_MACROS
`define BLK_OP_IF_NEW_CTX      0
`define BLK_OP_IF_CONTINUE_CTX 1
`define BLK_OP_LOAD_CTX_NUM    3:2
`define BLK_OP_SAVE_CTX_NUM    5:4
`define BLK_OP_END_COMP_OUTPUT 6
`endif

package sha256_pkg;

    localparam int BLK_OP_MSB   = 6;
    localparam int N_CTX        = 4;
    localparam int ROUND_CYCLES = 72;

    // Hash state, index 0 = a/H0 ... index 7 = h/H7.
    typedef logic [7:0][31:0] hash_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Listed H7 first so that IV[0] is H0.
    localparam hash_t IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Input words arrive little-endian; the schedule wants big-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/sha256_block_engine_round.sv
// sha256_round: one combinational SHA-256 round.
//   state_i : current a..h (index 0 = a)
//   w_i     : schedule word W[t]
//   k_i     : round constant K[t]
//   state_o : next a..h
module sha256_round
    import sha256_pkg::*;
(
    input  hash_t       state_i,
    input  logic [31:0] w_i,
    input  logic [31:0] k_i,
    output hash_t       state_o
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] ch, maj, t1, t2;

    always_comb begin
        a   = state_i[0];
        b   = state_i[1];
        c   = state_i[2];
        d   = state_i[3];
        e   = state_i[4];
        f   = state_i[5];
        g   = state_i[6];
        h   = state_i[7];
        ch  = (e & f) ^ (~e & g);
        maj = (a & b) ^ (a & c) ^ (b & c);
        t1  = h + big_sigma1(e) + ch + k_i + w_i;
        t2  = big_sigma0(a) + maj;

        state_o[0] = t1 + t2;
        state_o[1] = a;
        state_o[2] = b;
        state_o[3] = c;
        state_o[4] = d + t1;
        state_o[5] = e;
        state_o[6] = f;
        state_o[7] = g;
    end

endmodule

// File: rtl/sha256_block_engine.sv
// sha256_block_engine: single-block SHA-256 compression engine.
//   CLK, RST            clock, asynchronous active-high reset
//   start               scheduler pulse; begins a block if idle and one is pending
//   input_seq_num       input buffer consumed next
//   ready               buffer selected by input_seq is empty
//   wr_en/in/wr_addr    little-endian word write into buffer[input_seq]
//   input_blk_op        block operation, latched with set_input_ready
//   input_seq           buffer select for writes
//   set_input_ready     marks buffer[input_seq] full (same-cycle word included)
//   dout/dout_en        digest stream, 16 halfwords
// Optional macro SHA256_CORE_DOUT_REG_EN adds a register stage on dout/dout_en.
module sha256_block_engine
    import sha256_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    output logic                input_seq_num,
    output logic                ready,
    input  logic                wr_en,
    input  logic [31:0]         in,
    input  logic [3:0]          wr_addr,
    input  logic [BLK_OP_MSB:0] input_blk_op,
    input  logic                input_seq,
    input  logic                set_input_ready,
    output logic [15:0]         dout,
    output logic                dout_en
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_SAVE  = 2'd2;

    // Control state (reset)
    logic [1:0]          state_q, state_d;
    logic [5:0]          rnd_q, rnd_d;
    logic                seq_q, seq_d;
    logic [1:0]          full_q, full_d;
    logic [BLK_OP_MSB:0] op_q [0:1];
    logic [BLK_OP_MSB:0] op_d [0:1];
    logic [BLK_OP_MSB:0] cur_op_q, cur_op_d;
    logic                out_act_q, out_act_d;
    logic [3:0]          out_cnt_q, out_cnt_d;
    logic [1:0]          out_slot_q, out_slot_d;

    // Datapath state (no reset needed)
    logic [31:0]         buf_q [0:1][0:15];
    logic [31:0]         buf_d [0:1][0:15];
    logic [31:0]         w_q [0:15];
    logic [31:0]         w_d [0:15];
    hash_t               hash_q, hash_d;
    hash_t               ctx_q [0:N_CTX-1];
    hash_t               ctx_d [0:N_CTX-1];

    hash_t               hash_next;
    hash_t               base_start;
    hash_t               base_save;
    logic [31:0]         w_next;
    logic [BLK_OP_MSB:0] start_op;

    sha256_round u_round (
        .state_i (hash_q),
        .w_i     (w_q[0]),
        .k_i     (K[rnd_q]),
        .state_o (hash_next)
    );

    // Window w_q[j] = W[t+j]; W[t+16] from the standard recurrence.
    assign w_next = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

    assign start_op      = op_q[seq_q];
    assign ready         = ~full_q[input_seq];
    assign input_seq_num = seq_q;

    // Initial context for a block starting now, and for the block being saved.
    // The load slot cannot change mid-block, so re-reading it at save time
    // avoids keeping a separate copy of the initial context.
    always_comb begin
        base_start = start_op[`BLK_OP_IF_NEW_CTX] ? IV : ctx_q[start_op[`BLK_OP_LOAD_CTX_NUM]];
        base_save  = cur_op_q[`BLK_OP_IF_NEW_CTX] ? IV : ctx_q[cur_op_q[`BLK_OP_LOAD_CTX_NUM]];
    end

    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        seq_d      = seq_q;
        full_d     = full_q;
        op_d       = op_q;
        cur_op_d   = cur_op_q;
        out_act_d  = out_act_q;
        out_cnt_d  = out_cnt_q;
        out_slot_d = out_slot_q;
        buf_d      = buf_q;
        w_d        = w_q;
        hash_d     = hash_q;
        ctx_d      = ctx_q;

        // Write side: a full buffer ignores both writes and set_input_ready.
        if (!full_q[input_seq]) begin
            if (wr_en) begin
                buf_d[input_seq][wr_addr] = in;
            end
            if (set_input_ready) begin
                full_d[input_seq] = 1'b1;
                op_d[input_seq]   = input_blk_op;
            end
        end

        if (out_act_q) begin
            out_cnt_d = out_cnt_q + 4'd1;
            if (out_cnt_q == 4'd15) begin
                out_act_d = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start && full_q[seq_q]) begin
                    state_d  = ST_ROUND;
                    rnd_d    = 6'd0;
                    cur_op_d = start_op;
                    hash_d   = base_start;
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = bswap32(buf_q[seq_q][i]);
                    end
                end
            end
            ST_ROUND: begin
                hash_d = hash_next;
                for (int i = 0; i < 15; i++) begin
                    w_d[i] = w_q[i + 1];
                end
                w_d[15] = w_next;
                rnd_d   = rnd_q + 6'd1;
                if (rnd_q == 6'd63) begin
                    state_d       = ST_SAVE;
                    full_d[seq_q] = 1'b0;
                    seq_d         = ~seq_q;
                end
            end
            ST_SAVE: begin
                for (int i = 0; i < 8; i++) begin
                    ctx_d[cur_op_q[`BLK_OP_SAVE_CTX_NUM]][i] = base_save[i] + hash_q[i];
                end
                state_d = ST_IDLE;
                if (cur_op_q[`BLK_OP_END_COMP_OUTPUT]) begin
                    out_act_d  = 1'b1;
                    out_cnt_d  = 4'd0;
                    out_slot_d = cur_op_q[`BLK_OP_SAVE_CTX_NUM];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            rnd_q      <= 6'd0;
            seq_q      <= 1'b0;
            full_q     <= 2'b00;
            op_q       <= '{default: '0};
            cur_op_q   <= '0;
            out_act_q  <= 1'b0;
            out_cnt_q  <= 4'd0;
            out_slot_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            rnd_q      <= rnd_d;
            seq_q      <= seq_d;
            full_q     <= full_d;
            op_q       <= op_d;
            cur_op_q   <= cur_op_d;
            out_act_q  <= out_act_d;
            out_cnt_q  <= out_cnt_d;
            out_slot_q <= out_slot_d;
        end
    end

    always_ff @(posedge CLK) begin
        buf_q  <= buf_d;
        w_q    <= w_d;
        hash_q <= hash_d;
        ctx_q  <= ctx_d;
    end

    // Output mux: halfword k carries bytes {b(2k+1), b(2k)} of the digest.
    logic [31:0] out_word;
    logic [15:0] dout_c;
    logic        dout_en_c;

    always_comb begin
        out_word  = ctx_q[out_slot_q][out_cnt_q[3:1]];
        dout_c    = out_cnt_q[0] ? {out_word[7:0], out_word[15:8]}
                                 : {out_word[23:16], out_word[31:24]};
        if (!out_act_q) begin
            dout_c = 16'h0000;
        end
        dout_en_c = out_act_q;
    end

`ifdef SHA256_CORE_DOUT_REG_EN
    logic [15:0] dout_q;
    logic        dout_en_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_q    <= 16'h0000;
            dout_en_q <= 1'b0;
        end else begin
            dout_q    <= dout_c;
            dout_en_q <= dout_en_c;
        end
    end

    assign dout    = dout_q;
    assign dout_en = dout_en_q;
`else
    assign dout    = dout_c;
    assign dout_en = dout_en_c;
`endif

    logic unused_continue;
    assign unused_continue = cur_op_q[`BLK_OP_IF_CONTINUE_CTX];

endmodule

// File: tb/tb_sha256_block_engine.sv
// Directed bench for sha256_block_engine: known SHA-256 vectors, double
// buffering, context continuation, idle/empty start and mid-block reset.
module tb_sha256_block_engine;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        input_seq_num;
    logic        ready;
    logic        wr_en;
    logic [31:0] in;
    logic [3:0]  wr_addr;
    logic [6:0]  input_blk_op;
    logic        input_seq;
    logic        set_input_ready;
    logic [15:0] dout;
    logic        dout_en;

    int n_checks = 0;
    int n_errors = 0;

    // Every dout_en cycle lands here, indexed by running count.
    logic [15:0] cap [0:255];
    int          en_total = 0;

    always #5 CLK = ~CLK;

    sha256_block_engine u_dut (
        .CLK             (CLK),
        .RST             (RST),
        .start           (start),
        .input_seq_num   (input_seq_num),
        .ready           (ready),
        .wr_en           (wr_en),
        .in              (in),
        .wr_addr         (wr_addr),
        .input_blk_op    (input_blk_op),
        .input_seq       (input_seq),
        .set_input_ready (set_input_ready),
        .dout            (dout),
        .dout_en         (dout_en)
    );

    always @(negedge CLK) begin
        if (dout_en) begin
            if (en_total < 256) cap[en_total] <= dout;
            en_total <= en_total + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Rebuild digest word i (big-endian) from captured halfwords at base.
    function automatic logic [31:0] cap_word(input int base, input int i);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = cap[base + 2 * i];
        hi = cap[base + 2 * i + 1];
        return {lo[7:0], lo[15:8], hi[7:0], hi[15:8]};
    endfunction

    // msg holds the 16 raw input words, word 0 in the top 32 bits.
    task automatic write_block(input logic sq, input logic [511:0] msg, input logic [6:0] op);
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            wr_en           = 1'b1;
            wr_addr         = i[3:0];
            in              = msg[511 - 32 * i -: 32];
            input_seq       = sq;
            input_blk_op    = op;
            set_input_ready = (i == 15);
        end
        @(negedge CLK);
        wr_en           = 1'b0;
        set_input_ready = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int base);
        for (int c = 0; c < 200 && en_total < base + 16; c++) @(negedge CLK);
        repeat (4) @(negedge CLK);
        check_eq(tag, en_total - base, 16);
    endtask

    localparam logic [511:0] HELLO1 = {
        32'h6c6c6548, 32'h6f77206f, 32'h21646c72, 32'h746c6173,
        32'h69727473, 32'h6548676e, 32'h206f6c6c, 32'h6c726f77,
        32'h00802164, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h10010000
    };
    localparam logic [511:0] HELLO2 = {
        32'h6c6c6548, 32'h6f77206f, 32'h21646c72, 32'h746c6173,
        32'h69727473, 32'h304b676e, 32'h4b1a2f31, 32'he12f0a69,
        32'h65488c9a, 32'h206f6c6c, 32'h6c726f77, 32'h65482164,
        32'h206f6c6c, 32'h6c726f77, 32'h304b2164, 32'h4b1a2f31
    };
    // "abc", padded, length 24 bits
    localparam logic [511:0] ABC = {
        32'h80636261, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h18000000
    };
    localparam logic [255:0] ABC_DIG = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };
    // "abcdbcdecdef...nopq" (56 bytes), two blocks, length 448 bits
    localparam logic [511:0] TWO_B1 = {
        32'h64636261, 32'h65646362, 32'h66656463, 32'h67666564,
        32'h68676665, 32'h69686766, 32'h6a696867, 32'h6b6a6968,
        32'h6c6b6a69, 32'h6d6c6b6a, 32'h6e6d6c6b, 32'h6f6e6d6c,
        32'h706f6e6d, 32'h71706f6e, 32'h00000080, 32'h00000000
    };
    localparam logic [511:0] TWO_B2 = {
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'hc0010000
    };
    localparam logic [255:0] TWO_DIG = {
        32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1
    };

    // op = {END_OUT, SAVE[1:0], LOAD[1:0], CONTINUE, NEW}
    initial begin
        int base;
        RST = 1'b1; start = 1'b0; wr_en = 1'b0; in = '0; wr_addr = '0;
        input_blk_op = '0; input_seq = 1'b0; set_input_ready = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_eq("rst_ready", ready, 1);
        check_eq("rst_seq", input_seq_num, 0);
        check_eq("rst_dout_en", dout_en, 0);
        check_eq("rst_dout", dout, 0);

        // Hello block 1: NEW, save slot 0, output
        write_block(1'b0, HELLO1, 7'b1_00_00_0_1);
        check_eq("hs_ready_full", ready, 0);
        check_eq("hs_seq_before", input_seq_num, 0);
        base = en_total;
        pulse_start();
        wait_out("h1_count", base);
        check_eq("h1_dout0", cap[base], 16'h304b);
        check_eq("h1_dout1", cap[base + 1], 16'h2f31);
        check_eq("h1_H0", cap_word(base, 0), 32'h4b30312f);
        check_eq("h1_H1", cap_word(base, 1), 32'h1a4b690a);
        check_eq("h1_H6", cap_word(base, 6), 32'h6a322253);
        check_eq("h1_H7", cap_word(base, 7), 32'hbd37bfc1);
        check_eq("hs_ready_freed", ready, 1);
        check_eq("hs_seq_after", input_seq_num, 1);

        // Hello block 2: NEW, save slot 1, output
        write_block(1'b1, HELLO2, 7'b1_01_00_0_1);
        base = en_total;
        pulse_start();
        wait_out("h2_count", base);
        check_eq("h2_H0", cap_word(base, 0), 32'h4d2bbb07);
        check_eq("h2_H7", cap_word(base, 7), 32'hb3c2ba3e);
        check_eq("h2_seq", input_seq_num, 0);

        // "abc": NEW, save slot 2, output
        write_block(1'b0, ABC, 7'b1_10_00_0_1);
        base = en_total;
        pulse_start();
        wait_out("abc_count", base);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("abc_H%0d", i), cap_word(base, i), ABC_DIG[255 - 32 * i -: 32]);
        end

        // Two-block message: block 1 saves to slot 1 with no output; block 2
        // is written while block 1 runs, a start during the run is ignored.
        base = en_total;
        write_block(1'b1, TWO_B1, 7'b0_01_00_0_1);
        pulse_start();
        repeat (5) @(negedge CLK);
        write_block(1'b0, TWO_B2, 7'b1_11_01_0_0);
        pulse_start();
        repeat (60) @(negedge CLK);
        check_eq("busy_no_out", en_total - base, 0);
        check_eq("busy_seq", input_seq_num, 0);
        input_seq = 1'b0;
        @(negedge CLK);
        check_eq("busy_b2_pending", ready, 0);
        pulse_start();
        wait_out("two_count", base);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("two_H%0d", i), cap_word(base, i), TWO_DIG[255 - 32 * i -: 32]);
        end
        check_eq("two_seq", input_seq_num, 1);

        // start with both buffers empty
        base = en_total;
        input_seq = 1'b1;
        pulse_start();
        repeat (100) @(negedge CLK);
        check_eq("empty_no_out", en_total - base, 0);
        check_eq("empty_seq", input_seq_num, 1);
        check_eq("empty_ready", ready, 1);

        // Reset in the middle of the rounds
        write_block(1'b1, HELLO1, 7'b1_00_00_0_1);
        base = en_total;
        pulse_start();
        repeat (30) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (100) @(negedge CLK);
        check_eq("rstmid_no_out", en_total - base, 0);
        check_eq("rstmid_dout_en", dout_en, 0);
        check_eq("rstmid_ready", ready, 1);
        check_eq("rstmid_seq", input_seq_num, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
